burst_ram_cache: RTL and testbench
==================================

Name: burst_ram_cache

Overview:
- Direct-mapped, write-back, write-allocate data cache between a 32-bit byte-enabled requester port and a 64-bit burst RAM (PSRAM-style) controller.
- Sits inside the RAM/IO block, under the address/byte-lane conversion logic.
- Hits complete combinationally with no stall. Misses evict a dirty line with a 4-beat write burst, then fill the line with a 4-beat read burst.

Parameters:
- LINE_IX_BITWIDTH, 1: cache has 2^LINE_IX_BITWIDTH lines.
- RAM_DEPTH_BITWIDTH, 10: width of br_addr.
- RAM_ADDRESSING_MODE, 3: log2 of bytes per br_addr unit; 3 means 64-bit words, so br_addr = byte_address >> 3, truncated to RAM_DEPTH_BITWIDTH.
- ADDRESS_BITWIDTH, 32: requester byte-address width.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  request valid.
- address  in  ADDRESS_BITWIDTH  byte address; bits[1:0] are always 0.
- data_in  in  32  write data, already placed in its byte lanes.
- write_enable  in  4  per-byte write strobes; 0 means read.
- data_out  out  32  word at address.
- data_out_ready  out  1  data_out valid / write accepted this cycle.
- busy  out  1  miss being serviced.
- br_cmd  out  1  0 read, 1 write.
- br_cmd_en  out  1  one-cycle command strobe.
- br_addr  out  RAM_DEPTH_BITWIDTH  burst start address.
- br_wr_data  out  64  write beat.
- br_data_mask  out  8  constant 0 (all bytes written).
- br_rd_data  in  64  read beat.
- br_rd_data_valid  in  1  read beat valid.

Behaviour:
- Line geometry: 32 bytes = 8 words = 4 beats of 64 bits.
- Address split:
  - column = address[4:2]
  - index = address[4+LINE_IX_BITWIDTH:5]
  - tag = remaining upper bits
- Per line storage: valid, dirty, tag, 8 data words.
- Beat packing is little-endian: beat k holds word 2k in [31:0] and word 2k+1 in [63:32].
- hit = valid[index] && tag[index]==tag.
- States: IDLE, WR_BURST, RD_CMD, RD_DATA.

Outputs:
- data_out = line word at column, combinational, always driven from the indexed line.
- data_out_ready = enable && hit && state==IDLE (combinational).
- busy = (state!=IDLE) || (enable && !hit).

IDLE:
- Write hit (write_enable != 0): on the clock edge, update only the strobed bytes and set dirty. No stall; data_out reflects the new bytes from the next cycle.
- Miss, line dirty:
  - Issue br_cmd=1, br_cmd_en=1, br_addr = old line base (old tag, index) >> 3, br_wr_data = beat 0.
  - Go to WR_BURST.
- Miss, line clean or invalid: issue br_cmd=0, br_cmd_en=1, br_addr = new line base >> 3. Go to RD_DATA.

WR_BURST:
- br_cmd_en=0; drive beats 1, 2, 3 on three consecutive cycles.
- Then go to RD_CMD.

RD_CMD:
- One-cycle read command for the new line, then go to RD_DATA.

RD_DATA:
- Store each beat when br_rd_data_valid is high, in order 0..3. Non-valid cycles between beats are tolerated.
- After beat 3: valid=1, dirty=0, tag updated; go to IDLE.
- The held request then hits. A pending write merges in the first IDLE cycle and sets dirty.

Handshake and boundary rules:
- br_cmd_en is high for exactly one cycle per burst.
- br_addr low 2 bits are always 0 (line aligned).
- br_wr_data holds its value when not bursting.
- The requester holds enable, address, data_in and write_enable stable while busy. Changes during a miss are ignored until IDLE.
- enable=0 means no state change and no RAM command. data_out is don't-care.
- br_rd_data_valid outside RD_DATA is ignored.
- Reset:
  - All valid and dirty bits cleared; state=IDLE.
  - br_cmd=0, br_cmd_en=0, br_addr=0, br_wr_data=0; busy=0 unless a request is present.
  - Reset mid-burst aborts the burst; the aborted line stays invalid.

Test Plan:
1. After reset, read 0x0000_0000: busy=1, one read command with br_cmd=0, br_addr=0. Return beats 0x11111111_00000000, 0x33333333_22222222, 0x55555555_44444444, 0x77777777_66666666. Then busy=0, data_out_ready=1, data_out=0x00000000. Read 0x14 -> 0x55555555 with no RAM command.
2. Write hit to 0x04, write_enable=4'b0010, data_in=0x0000AB00: no stall. Reading 0x04 returns 0x1111AB11.
3. Then read 0x40, which maps to the same index with LINE_IX_BITWIDTH=1. Require:
   - Write burst first: br_cmd=1, br_addr=0, four beats with beat 0 = 0x1111AB11_00000000.
   - Then a read command with br_addr=0x08.
4. Read miss on a clean line: no write burst; the read command is issued in the first busy cycle.
5. Fill with gaps, br_rd_data_valid pattern 1,0,1,0,0,1,1: words are placed correctly and busy drops after the 4th valid beat.
6. Assert rst_n low during RD_DATA, then re-read the same address: a full miss recurs with a new read command.

Source files
------------

// File: rtl/burst_ram_cache.sv
// burst_ram_cache
//   Direct-mapped, write-back, write-allocate data cache placed between a
//   32-bit byte-enabled requester and a 64-bit burst RAM controller.
//   Lines are 32 bytes (8 words, 4 beats of 64 bits, little-endian packing).
//   Hits complete combinationally; a miss evicts a dirty line with a 4-beat
//   write burst, then refills with a 4-beat read burst.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   enable              request valid
//   address             byte address (bits [1:0] always zero)
//   data_in             write data in its byte lanes
//   write_enable        per-byte strobes, 0 = read
//   data_out            word at address from the indexed line
//   data_out_ready      read data valid / write accepted this cycle
//   busy                miss in progress or pending
//   br_cmd              burst command: 0 read, 1 write
//   br_cmd_en           one-cycle command strobe
//   br_addr             burst start address (RAM word units)
//   br_wr_data          write beat
//   br_data_mask        byte mask, always 0
//   br_rd_data          read beat
//   br_rd_data_valid    read beat valid
module burst_ram_cache #(
  parameter int LINE_IX_BITWIDTH    = 1,
  parameter int RAM_DEPTH_BITWIDTH  = 10,
  parameter int RAM_ADDRESSING_MODE = 3,
  parameter int ADDRESS_BITWIDTH    = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic [ADDRESS_BITWIDTH-1:0]   address,
  input  logic [31:0]                   data_in,
  input  logic [3:0]                    write_enable,
  output logic [31:0]                   data_out,
  output logic                          data_out_ready,
  output logic                          busy,
  output logic                          br_cmd,
  output logic                          br_cmd_en,
  output logic [RAM_DEPTH_BITWIDTH-1:0] br_addr,
  output logic [63:0]                   br_wr_data,
  output logic [7:0]                    br_data_mask,
  input  logic [63:0]                   br_rd_data,
  input  logic                          br_rd_data_valid
);

  localparam int LINES = 1 << LINE_IX_BITWIDTH;
  localparam int TAG_W = ADDRESS_BITWIDTH - 5 - LINE_IX_BITWIDTH;
  localparam int WA_W  = LINE_IX_BITWIDTH + 3;

  typedef enum logic [1:0] {IDLE, WR_BURST, RD_CMD, RD_DATA} state_t;

  state_t state_q, state_d;

  logic [TAG_W-1:0]            req_tag;
  logic [LINE_IX_BITWIDTH-1:0] req_ix;
  logic [2:0]                  req_col;
  logic                        unused_addr_bits;

  assign req_tag          = address[ADDRESS_BITWIDTH-1 -: TAG_W];
  assign req_ix           = address[5 +: LINE_IX_BITWIDTH];
  assign req_col          = address[4:2];
  assign unused_addr_bits = ^address[1:0];

  logic [LINES-1:0] valid_q, dirty_q;
  logic [TAG_W-1:0] tag_q [LINES];
  logic [31:0]      mem   [LINES*8];

  // Miss context is latched so requester changes during a miss are ignored.
  logic [TAG_W-1:0]            miss_tag_q, miss_tag_d;
  logic [LINE_IX_BITWIDTH-1:0] miss_ix_q, miss_ix_d;
  logic [1:0]                  beat_q, beat_d;

  logic                          br_cmd_d, br_cmd_en_d;
  logic [RAM_DEPTH_BITWIDTH-1:0] br_addr_d;
  logic [63:0]                   br_wr_data_d;

  logic hit, wr_hit, fill_we, fill_done;

  // Source line/beat for eviction data: beat 0 is fetched while still in IDLE.
  logic [LINE_IX_BITWIDTH-1:0] wb_ix;
  logic [1:0]                  wb_beat;
  logic [63:0]                 wb_data;

  function automatic logic [RAM_DEPTH_BITWIDTH-1:0] line_addr(
    input logic [TAG_W-1:0]            t,
    input logic [LINE_IX_BITWIDTH-1:0] ix
  );
    return RAM_DEPTH_BITWIDTH'({t, ix, 5'b0} >> RAM_ADDRESSING_MODE);
  endfunction

  assign hit            = valid_q[req_ix] && (tag_q[req_ix] == req_tag);
  assign data_out       = mem[{req_ix, req_col}];
  assign data_out_ready = enable && hit && (state_q == IDLE);
  assign busy           = (state_q != IDLE) || (enable && !hit);
  assign wr_hit         = (state_q == IDLE) && enable && hit && (write_enable != 4'b0000);
  assign br_data_mask   = '0;

  assign wb_ix   = (state_q == IDLE) ? req_ix : miss_ix_q;
  assign wb_beat = (state_q == IDLE) ? 2'd0   : beat_q;
  assign wb_data = {mem[{wb_ix, wb_beat, 1'b1}], mem[{wb_ix, wb_beat, 1'b0}]};

  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    miss_tag_d   = miss_tag_q;
    miss_ix_d    = miss_ix_q;
    br_cmd_d     = br_cmd;
    br_cmd_en_d  = 1'b0;
    br_addr_d    = br_addr;
    br_wr_data_d = br_wr_data;
    fill_we      = 1'b0;
    fill_done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable && !hit) begin
          miss_tag_d  = req_tag;
          miss_ix_d   = req_ix;
          br_cmd_en_d = 1'b1;
          if (valid_q[req_ix] && dirty_q[req_ix]) begin
            br_cmd_d     = 1'b1;
            br_addr_d    = line_addr(tag_q[req_ix], req_ix);
            br_wr_data_d = wb_data;
            beat_d       = 2'd1;
            state_d      = WR_BURST;
          end else begin
            br_cmd_d  = 1'b0;
            br_addr_d = line_addr(req_tag, req_ix);
            beat_d    = 2'd0;
            state_d   = RD_DATA;
          end
        end
      end
      WR_BURST: begin
        br_wr_data_d = wb_data;
        beat_d       = beat_q + 2'd1;
        if (beat_q == 2'd3) state_d = RD_CMD;
      end
      RD_CMD: begin
        br_cmd_en_d = 1'b1;
        br_cmd_d    = 1'b0;
        br_addr_d   = line_addr(miss_tag_q, miss_ix_q);
        beat_d      = 2'd0;
        state_d     = RD_DATA;
      end
      RD_DATA: begin
        if (br_rd_data_valid) begin
          fill_we = 1'b1;
          beat_d  = beat_q + 2'd1;
          if (beat_q == 2'd3) begin
            fill_done = 1'b1;
            state_d   = IDLE;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      beat_q     <= '0;
      miss_tag_q <= '0;
      miss_ix_q  <= '0;
      valid_q    <= '0;
      dirty_q    <= '0;
      br_cmd     <= 1'b0;
      br_cmd_en  <= 1'b0;
      br_addr    <= '0;
      br_wr_data <= '0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      miss_tag_q <= miss_tag_d;
      miss_ix_q  <= miss_ix_d;
      br_cmd     <= br_cmd_d;
      br_cmd_en  <= br_cmd_en_d;
      br_addr    <= br_addr_d;
      br_wr_data <= br_wr_data_d;
      if (wr_hit) dirty_q[req_ix] <= 1'b1;
      if (fill_done) begin
        valid_q[miss_ix_q] <= 1'b1;
        dirty_q[miss_ix_q] <= 1'b0;
      end
    end
  end

  // Line data and tags need no reset: the valid bits gate every use.
  always_ff @(posedge clk) begin
    if (wr_hit) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (write_enable[b]) mem[{req_ix, req_col}][8*b +: 8] <= data_in[8*b +: 8];
      end
    end
    if (fill_we) begin
      mem[{miss_ix_q, beat_q, 1'b0}] <= br_rd_data[31:0];
      mem[{miss_ix_q, beat_q, 1'b1}] <= br_rd_data[63:32];
    end
    if (fill_done) tag_q[miss_ix_q] <= miss_tag_q;
  end

endmodule

// File: tb/tb_burst_ram_cache.sv
// tb_burst_ram_cache
//   Directed bench for burst_ram_cache: fills, hits, byte-write hits, dirty
//   eviction, gapped refills, reset during a refill and write-miss merging.
//   Inputs change 1 time unit after the rising edge; outputs are sampled
//   there as well, away from the edge.
module tb_burst_ram_cache;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [31:0] address;
  logic [31:0] data_in;
  logic [3:0]  write_enable;
  logic [31:0] data_out;
  logic        data_out_ready;
  logic        busy;
  logic        br_cmd;
  logic        br_cmd_en;
  logic [9:0]  br_addr;
  logic [63:0] br_wr_data;
  logic [7:0]  br_data_mask;
  logic [63:0] br_rd_data;
  logic        br_rd_data_valid;

  int n_checks = 0;
  int n_fail   = 0;
  int cmd_cnt  = 0;
  int c0;

  burst_ram_cache #(
    .LINE_IX_BITWIDTH   (1),
    .RAM_DEPTH_BITWIDTH (10),
    .RAM_ADDRESSING_MODE(3),
    .ADDRESS_BITWIDTH   (32)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .enable          (enable),
    .address         (address),
    .data_in         (data_in),
    .write_enable    (write_enable),
    .data_out        (data_out),
    .data_out_ready  (data_out_ready),
    .busy            (busy),
    .br_cmd          (br_cmd),
    .br_cmd_en       (br_cmd_en),
    .br_addr         (br_addr),
    .br_wr_data      (br_wr_data),
    .br_data_mask    (br_data_mask),
    .br_rd_data      (br_rd_data),
    .br_rd_data_valid(br_rd_data_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (br_cmd_en) cmd_cnt++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One valid read beat for one cycle, then the bus returns to junk/idle.
  task automatic beat(input logic [63:0] d);
    br_rd_data_valid = 1'b1;
    br_rd_data       = d;
    step();
    br_rd_data_valid = 1'b0;
    br_rd_data       = 64'hDEADBEEF_DEADBEEF;
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; address = '0; data_in = '0; write_enable = '0;
    br_rd_data = 64'hDEADBEEF_DEADBEEF; br_rd_data_valid = 1'b0;
    repeat (2) step();
    check("rst_cmd_en", br_cmd_en, 0);
    check("rst_cmd", br_cmd, 0);
    check("rst_addr", br_addr, 0);
    check("rst_wr_data", br_wr_data, 0);
    check("rst_busy", busy, 0);
    check("rst_mask", br_data_mask, 0);
    rst_n = 1'b1;
    step();

    // Cold read miss at 0x00
    enable = 1'b1; address = 32'h0; #1;
    check("t1_busy", busy, 1);
    check("t1_rdy", data_out_ready, 0);
    c0 = cmd_cnt;
    step();
    check("t1_cmd_en", br_cmd_en, 1);
    check("t1_cmd", br_cmd, 0);
    check("t1_addr", br_addr, 10'h000);
    step();
    check("t1_cmd_pulse", br_cmd_en, 0);
    check("t1_busy_fill", busy, 1);
    beat(64'h11111111_00000000);
    beat(64'h33333333_22222222);
    beat(64'h55555555_44444444);
    beat(64'h77777777_66666666);
    check("t1_busy_done", busy, 0);
    check("t1_rdy_done", data_out_ready, 1);
    check("t1_data0", data_out, 32'h00000000);
    address = 32'h14; #1;
    check("t1_data14", data_out, 32'h55555555);
    check("t1_rdy14", data_out_ready, 1);
    step();
    check("t1_one_cmd", cmd_cnt - c0, 1);

    // Byte write hit
    address = 32'h04; write_enable = 4'b0010; data_in = 32'h0000AB00; #1;
    check("t2_busy", busy, 0);
    check("t2_rdy", data_out_ready, 1);
    step();
    write_enable = 4'b0000; #1;
    check("t2_data", data_out, 32'h1111AB11);
    check("t2_no_cmd", cmd_cnt - c0, 1);

    // Dirty eviction on conflict miss, then refill with gaps 1,0,1,0,0,1,1
    address = 32'h40; #1;
    check("t3_busy", busy, 1);
    c0 = cmd_cnt;
    step();
    check("t3_wcmd_en", br_cmd_en, 1);
    check("t3_wcmd", br_cmd, 1);
    check("t3_waddr", br_addr, 10'h000);
    check("t3_beat0", br_wr_data, 64'h1111AB11_00000000);
    step();
    check("t3_wcmd_pulse", br_cmd_en, 0);
    check("t3_beat1", br_wr_data, 64'h33333333_22222222);
    step();
    check("t3_beat2", br_wr_data, 64'h55555555_44444444);
    step();
    check("t3_beat3", br_wr_data, 64'h77777777_66666666);
    check("t3_no_rcmd_yet", br_cmd_en, 0);
    step();
    check("t3_rcmd_en", br_cmd_en, 1);
    check("t3_rcmd", br_cmd, 0);
    check("t3_raddr", br_addr, 10'h008);
    check("t3_wr_hold", br_wr_data, 64'h77777777_66666666);
    step();
    check("t3_rcmd_pulse", br_cmd_en, 0);
    beat(64'hA1A1A1A1_A0A0A0A0);
    step();
    beat(64'hA3A3A3A3_A2A2A2A2);
    step();
    step();
    beat(64'hA5A5A5A5_A4A4A4A4);
    check("t5_busy_b3", busy, 1);
    beat(64'hA7A7A7A7_A6A6A6A6);
    check("t5_busy_done", busy, 0);
    check("t5_rdy", data_out_ready, 1);
    check("t5_data40", data_out, 32'hA0A0A0A0);
    address = 32'h4C; #1;
    check("t5_data4c", data_out, 32'hA3A3A3A3);
    address = 32'h5C; #1;
    check("t5_data5c", data_out, 32'hA7A7A7A7);
    check("t3_two_cmds", cmd_cnt - c0, 2);

    // Clean miss on an invalid line, reset in the middle of its refill
    address = 32'h20; #1;
    check("t4_busy", busy, 1);
    step();
    check("t4_cmd_en", br_cmd_en, 1);
    check("t4_cmd", br_cmd, 0);
    check("t4_addr", br_addr, 10'h004);
    step();
    beat(64'hC1C1C1C1_C0C0C0C0);
    step();
    rst_n = 1'b0; #1;
    check("t6_rst_busy", busy, 1);
    check("t6_rst_cmd_en", br_cmd_en, 0);
    check("t6_rst_addr", br_addr, 0);
    check("t6_rst_wr_data", br_wr_data, 0);
    step();
    rst_n = 1'b1;
    c0 = cmd_cnt;
    step();
    check("t6_cmd_en", br_cmd_en, 1);
    check("t6_cmd", br_cmd, 0);
    check("t6_addr", br_addr, 10'h004);
    step();
    beat(64'hC1C1C1C1_C0C0C0C0);
    beat(64'hC3C3C3C3_C2C2C2C2);
    beat(64'hC5C5C5C5_C4C4C4C4);
    beat(64'hC7C7C7C7_C6C6C6C6);
    check("t6_busy_done", busy, 0);
    check("t6_data20", data_out, 32'hC0C0C0C0);
    address = 32'h3C; #1;
    check("t6_data3c", data_out, 32'hC7C7C7C7);
    check("t6_one_cmd", cmd_cnt - c0, 1);
    address = 32'h40; #1;
    check("t6_line0_invalid", busy, 1);

    // Write miss on a clean line: write merges after the refill
    address = 32'h64; write_enable = 4'hF; data_in = 32'hCAFEF00D; #1;
    check("t7_busy", busy, 1);
    check("t7_rdy", data_out_ready, 0);
    step();
    check("t7_cmd_en", br_cmd_en, 1);
    check("t7_cmd", br_cmd, 0);
    check("t7_addr", br_addr, 10'h00C);
    step();
    beat(64'hD1D1D1D1_D0D0D0D0);
    beat(64'hD3D3D3D3_D2D2D2D2);
    beat(64'hD5D5D5D5_D4D4D4D4);
    beat(64'hD7D7D7D7_D6D6D6D6);
    check("t7_busy_done", busy, 0);
    check("t7_rdy_done", data_out_ready, 1);
    check("t7_pre_merge", data_out, 32'hD1D1D1D1);
    step();
    write_enable = 4'h0; #1;
    check("t7_merged", data_out, 32'hCAFEF00D);
    address = 32'h24; #1;
    step();
    check("t7_evict_cmd_en", br_cmd_en, 1);
    check("t7_evict_cmd", br_cmd, 1);
    check("t7_evict_addr", br_addr, 10'h00C);
    check("t7_evict_beat0", br_wr_data, 64'hCAFEF00D_D0D0D0D0);

    enable = 1'b0;
    repeat (6) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
